// File: rtl/alu_seq.sv
// alu_seq: sequential front-end for an external 16-bit ALU; multi-bit shifts iterate 1-bit ALU shifts.
// Condition codes are enabled by defining ALU_SEQ_CC_EN; otherwise cc_n/cc_z/cc_p are tied to 0.
module alu_seq #(
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [15:0]        req_a,
    input  logic [15:0]        req_b,
    input  logic [SHAMT_W-1:0] req_shamt,
    output logic [15:0]        alu_in1,
    output logic [15:0]        alu_in2,
    output logic [2:0]         alu_op,
    input  logic [15:0]        alu_out,
    input  logic               alu_zero,
    input  logic               alu_negative,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [15:0]        rsp_data,
    output logic               cc_n,
    output logic               cc_z,
    output logic               cc_p,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;
    state_t              r_state;
    logic [2:0]          r_op;
    logic [15:0]         r_a;
    logic [15:0]         r_b;
    logic [15:0]         r_work;
    logic [15:0]         r_rsp_data;
    logic [SHAMT_W-1:0]  r_cnt;
    logic                w_req_shift;
    logic                w_op_shift;
    logic                w_cap;

    assign w_req_shift = (req_op == 3'd4 || req_op == 3'd5) && req_shamt != '0;
    assign w_op_shift  = r_op == 3'd4 || r_op == 3'd5;
    // final-capture edge: end of EXEC or the last iteration of SHIFT
    assign w_cap       = r_state == EXEC || (r_state == SHIFT && r_cnt == SHAMT_W'(1));
    assign req_ready   = r_state == IDLE;
    assign rsp_valid   = r_state == RESP;
    assign busy        = r_state != IDLE;
    assign rsp_data    = r_rsp_data;

    always_comb begin
        alu_in1 = r_state == EXEC ? r_a : r_state == SHIFT ? r_work : 16'h0000;
        alu_in2 = r_state == EXEC ? r_b : 16'h0000;
        alu_op  = r_state == EXEC ? (w_op_shift ? 3'd7 : r_op) : r_state == SHIFT ? r_op : 3'd6;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_cap) r_rsp_data <= alu_out;
            case (r_state)
                IDLE: if (req_valid) begin
                    r_op    <= req_op;
                    r_a     <= req_a;
                    r_b     <= req_b;
                    r_work  <= req_a;
                    r_cnt   <= req_shamt;
                    r_state <= w_req_shift ? SHIFT : EXEC;
                end
                EXEC: r_state <= RESP;
                SHIFT: begin
                    r_work <= alu_out;
                    r_cnt  <= r_cnt - SHAMT_W'(1);
                    if (r_cnt == SHAMT_W'(1)) r_state <= RESP;
                end
                default: if (rsp_ready) r_state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_CC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {cc_n, cc_z, cc_p} <= 3'b010;
        else if (w_cap) {cc_n, cc_z, cc_p} <= {alu_negative, alu_zero, !alu_negative && !alu_zero};
    end
`else
    logic w_unused_flags;
    assign w_unused_flags = alu_negative ^ alu_zero;
    assign {cc_n, cc_z, cc_p} = 3'b000;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven check of alu_seq against a behavioural ALU, with a response scoreboard.
module tb_alu_seq;
    localparam int SW = 4;
`ifdef ALU_SEQ_CC_EN
    localparam logic [2:0] RST_CC = 3'b010;
`else
    localparam logic [2:0] RST_CC = 3'b000;
`endif
    logic clk = 0, rst = 1, req_valid = 0, rsp_ready = 0;
    logic req_ready, rsp_valid, busy, cc_n, cc_z, cc_p, alu_zero, alu_negative;
    logic [2:0] req_op = 0, alu_op;
    logic [15:0] req_a = 0, req_b = 0, alu_in1, alu_in2, alu_out, rsp_data;
    logic [SW-1:0] req_shamt = 0;
    int n_cmp = 0, n_err = 0;

    typedef struct {
        logic [2:0]    op;
        logic [15:0]   a;
        logic [15:0]   b;
        logic [SW-1:0] sh;
        logic          rdy;
        logic [15:0]   data;
        int            lat;
    } vec_t;
    typedef struct {
        logic [15:0] data;
        int          lat;
        logic [2:0]  cc;
    } exp_t;
    exp_t sb[$];
    vec_t tbl[13];

    alu_seq #(.SHAMT_W(SW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .cc_n(cc_n), .cc_z(cc_z), .cc_p(cc_p), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            3'd0:    alu_out = alu_in1 + alu_in2;
            3'd1:    alu_out = alu_in1 & alu_in2;
            3'd2:    alu_out = ~alu_in1;
            3'd3:    alu_out = alu_in1 ^ alu_in2;
            3'd4:    alu_out = alu_in1 << 1;
            3'd5:    alu_out = alu_in1 >> 1;
            3'd6:    alu_out = 16'h0000;
            default: alu_out = alu_in1;
        endcase
    end
    assign alu_zero     = alu_out == 16'h0000;
    assign alu_negative = alu_out[15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] cc_of(input logic [15:0] d);
        logic [2:0] c;
        c = {d[15], d == 16'h0000, !d[15] && d != 16'h0000};
`ifndef ALU_SEQ_CC_EN
        c = 3'b000;
`endif
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_req(input vec_t v);
        exp_t e;
        int k;
        int bad = 0;
        logic sh_op;
        logic iter;
        logic [2:0] aop;
        sh_op = v.op == 3'd4 || v.op == 3'd5;
        iter  = sh_op && v.sh != '0;
        aop   = iter ? v.op : sh_op ? 3'd7 : v.op;
        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready}, 1);
        req_valid = 1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        req_shamt = v.sh;
        rsp_ready = v.rdy;
        e.data = v.data;
        e.lat  = v.lat;
        e.cc   = cc_of(v.data);
        sb.push_back(e);
        @(negedge clk);
        req_valid = 0;
        k = 1;
        while (!rsp_valid && k < 64) begin
            if (alu_op !== aop || busy !== 1'b1 || alu_in2 !== (iter ? 16'h0 : v.b)) bad++;
            @(negedge clk);
            k++;
        end
        chk("rsp_timeout", {31'b0, rsp_valid}, 1);
        e = sb.pop_front();
        chk("rsp_data", {16'b0, rsp_data}, {16'b0, e.data});
        chk("latency", k, e.lat);
        chk("cc", {29'b0, cc_n, cc_z, cc_p}, {29'b0, e.cc});
        chk("busy_alu_drive", bad, 0);
        chk("resp_alu_op", {29'b0, alu_op}, 6);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("back_idle", {29'b0, busy, rsp_valid, req_ready}, 3'b001);
    endtask

    initial begin
        int bad;
        exp_t e;
        vec_t v;
        tbl[0]  = '{3'd0, 16'h7FFF, 16'h0001, 4'd0,  1'b0, 16'h8000, 2};
        tbl[1]  = '{3'd4, 16'h0001, 16'h0000, 4'd15, 1'b0, 16'h8000, 16};
        tbl[2]  = '{3'd5, 16'h0F00, 16'hFFFF, 4'd4,  1'b0, 16'h00F0, 5};
        tbl[3]  = '{3'd4, 16'h1234, 16'h0000, 4'd0,  1'b0, 16'h1234, 2};
        tbl[4]  = '{3'd1, 16'hF0F0, 16'h3C3C, 4'd5,  1'b1, 16'h3030, 2};
        tbl[5]  = '{3'd2, 16'h00FF, 16'h1234, 4'd0,  1'b0, 16'hFF00, 2};
        tbl[6]  = '{3'd3, 16'h1234, 16'hFFFF, 4'd0,  1'b0, 16'hEDCB, 2};
        tbl[7]  = '{3'd6, 16'h1234, 16'h5678, 4'd0,  1'b0, 16'h0000, 2};
        tbl[8]  = '{3'd7, 16'h0042, 16'h9999, 4'd0,  1'b1, 16'h0042, 2};
        tbl[9]  = '{3'd5, 16'h8000, 16'h0000, 4'd1,  1'b0, 16'h4000, 2};
        tbl[10] = '{3'd0, 16'hFFFF, 16'h0001, 4'd0,  1'b0, 16'h0000, 2};
        tbl[11] = '{3'd5, 16'h0001, 16'h0000, 4'd0,  1'b0, 16'h0001, 2};
        tbl[12] = '{3'd4, 16'h0003, 16'h0000, 4'd3,  1'b0, 16'h0018, 4};

        #12;
        chk("reset_ctrl", {29'b0, busy, rsp_valid, req_ready}, 3'b001);
        chk("reset_data", {16'b0, rsp_data}, 0);
        chk("reset_cc", {29'b0, cc_n, cc_z, cc_p}, {29'b0, RST_CC});
        chk("reset_alu", {13'b0, alu_op, alu_in1}, {13'b0, 3'd6, 16'h0});
        @(negedge clk);
        rst = 0;

        foreach (tbl[i]) do_req(tbl[i]);

        // reset during the third cycle of an 8-step shift discards the operation
        @(negedge clk);
        req_valid = 1;
        req_op    = 3'd4;
        req_a     = 16'h0001;
        req_b     = 16'h0000;
        req_shamt = 4'd8;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("shift_busy", {31'b0, busy}, 1);
        rst = 1;
        #1;
        chk("rst_abort_ctrl", {29'b0, busy, rsp_valid, req_ready}, 3'b001);
        chk("rst_abort_data", {16'b0, rsp_data}, 0);
        chk("rst_abort_cc", {29'b0, cc_n, cc_z, cc_p}, {29'b0, RST_CC});
        @(negedge clk);
        rst = 0;
        bad = 0;
        repeat (12) begin
            if (rsp_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("no_rsp_after_rst", bad, 0);
        v = '{3'd0, 16'h0002, 16'h0003, 4'd0, 1'b0, 16'h0005, 2};
        do_req(v);

        // held response: XOR to zero, rsp_ready low for 5 cycles, stray req_valid ignored
        @(negedge clk);
        req_valid = 1;
        req_op    = 3'd3;
        req_a     = 16'hA5A5;
        req_b     = 16'hA5A5;
        req_shamt = 4'd0;
        e.data = 16'h0000;
        e.lat  = 2;
        e.cc   = cc_of(16'h0000);
        sb.push_back(e);
        @(negedge clk);
        req_op = 3'd0;
        req_a  = 16'h1111;
        @(negedge clk);
        chk("hold_valid", {31'b0, rsp_valid}, 1);
        e = sb.pop_front();
        bad = 0;
        repeat (5) begin
            if (rsp_valid !== 1'b1 || rsp_data !== e.data || req_ready !== 1'b0 ||
                {cc_n, cc_z, cc_p} !== e.cc) bad++;
            @(negedge clk);
        end
        chk("hold_stable", bad, 0);
        chk("hold_data", {16'b0, rsp_data}, {16'b0, e.data});
        rsp_ready = 1;
        @(negedge clk);
        chk("release_idle", {29'b0, busy, rsp_valid, req_ready}, 3'b001);
        req_valid = 0;
        rsp_ready = 0;
        @(negedge clk);
        chk("no_accept_on_release", {31'b0, busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
